sevenseg_scan: RTL
==================

Name: sevenseg_scan

Overview:
- Time-multiplexed seven-segment display driver: the output-side counterpart to the pushbutton input conditioning, driving the board's common-anode digits and shared cathodes.
- Takes a packed hex value plus per-digit decimal-point and blank masks, then scans one digit at a time.
- Inserts a short all-off gap between digits to prevent ghosting.
- Sits between the counter/status logic and the board pins; latches new values only at frame boundaries so a frame never shows a mix of old and new digits.

Parameters:
- NUM_DIGITS, 8, number of multiplexed digits (2..8).
- DIGIT_CYCLES, 100000, clk cycles per digit slot (1 ms at 100 MHz); must exceed GAP_CYCLES.
- GAP_CYCLES, 2000, clk cycles at slot start with all anodes off (ghost suppression); must be ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  scan enable; low forces display dark.
- load  in  1  one-cycle strobe; captures value/dp_in/blank_in into the pending register.
- value  in  4*NUM_DIGITS  hex nibbles; digit 0 is the least-significant nibble.
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- blank_in  in  NUM_DIGITS  1 = digit forced dark.
- an  out  NUM_DIGITS  anode enables, active-low, one-hot-low when driving.
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal-point cathode, active-low.
- frame_start  out  1  one-cycle pulse when digit 0's slot begins.

Behaviour:
- Reset (reset=0, asynchronous): state OFF; an all 1s; seg 7'h7F; dp 1; frame_start 0; counters 0; pending and active registers 0; pending_valid 0.
- Registers:
  - pending: written on load; sets pending_valid.
  - active: copied from pending at each frame start if pending_valid, which then clears.
  - If load coincides with the frame-start copy, the new load wins: it is written to pending, pending_valid stays 1, and the older pending contents are copied to active.
- State OFF:
  - Outputs dark.
  - enable=1 moves to BLANK with digit index 0 and slot counter 0.
- State BLANK:
  - an all 1s, seg/dp dark.
  - Slot counter increments each cycle.
  - When counter == GAP_CYCLES-1, move to DRIVE.
- State DRIVE:
  - an[idx]=0, all other anodes 1.
  - seg is the hex decode of nibble idx of active; dp = ~active_dp[idx].
  - If active_blank[idx]=1, seg=7'h7F and dp=1, but an[idx] is still asserted.
  - When counter == DIGIT_CYCLES-1: counter←0, idx←idx+1, wrapping NUM_DIGITS-1→0; move to BLANK.
- frame_start:
  - Asserted for the single cycle in which the FSM enters BLANK with idx=0, including the first entry from OFF.
  - The active-register update happens on that same edge.
- All outputs are registered. an/seg/dp change on the clock edge after the state change, i.e. one cycle of latency from the state register.
- enable deasserted in any state: go to OFF next cycle, with outputs dark the cycle after. idx and counter reset to 0; pending is retained.
- Hex decode: 0..F standard patterns. Active-high {g..a} patterns: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71. Outputs are inverted for the active-low pins.
- Counter width: $clog2(DIGIT_CYCLES). Digit index width: $clog2(NUM_DIGITS), minimum 1.

Optional Feature:
- Macro SEVENSEG_LZ_BLANK_EN.
- Defined:
  - At frame-start copy, compute a leading-zero mask from the top digit downward.
  - Each digit that is 0 and has all higher digits 0 is blanked (OR'd into active_blank).
  - Digit 0 is never auto-blanked.
- Undefined: only blank_in controls blanking; zeros display as "0".

Decomposition:
- Package sevenseg_pkg:
  - state encoding OFF/BLANK/DRIVE (2-bit localparams).
  - 16-entry hex-to-segment constant table, active-high {g..a}.
  - function hex2seg(nibble).
- Sub-module hex_to_7seg: purely combinational nibble→seg decode, instantiated once on the muxed nibble.

Test Plan:
Use NUM_DIGITS=4, DIGIT_CYCLES=10, GAP_CYCLES=2.
- Reset/idle: reset=0 then 1, enable=0 for 50 cycles → an=4'hF, seg=7'h7F, dp=1, frame_start never 1.
- Basic scan: load value=16'h12AF, dp_in=4'b0100, enable=1.
  - an sequence: 1110,1101,1011,0111, each low for 8 cycles with 2 all-off cycles before it.
  - seg during digit0 = ~7'h71 (F); during digit2 dp=0; during digit3 seg = ~7'h06.
  - frame_start period = 40 cycles.
- Frame-boundary update: load 16'h0000 mid-frame (digit 1 slot) → digits 1–3 of the current frame still show the old value; new value appears from the next frame_start.
- Blank mask: blank_in=4'b1000 → during digit3 slot, an=0111 while seg=7'h7F and dp=1.
- Enable drop mid-DRIVE on digit 2 → dark within 2 cycles. Re-enable → restart at digit 0 with a frame_start pulse.
- SEVENSEG_LZ_BLANK_EN defined, value=16'h0050:
  - digits 3 and 2 dark, digit 1 shows 5, digit 0 shows 0.
  - value=16'h0000 → only digit 0 lit ("0").

Source files
------------

// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared definitions for the seven-segment scan driver.
//   scan_state_e : scan FSM states (OFF / BLANK / DRIVE).
//   SEG_OFF      : cathode pattern with every segment dark (active-low pins).
//   HEX_SEG      : 16-entry hex-to-segment table, active-high {g,f,e,d,c,b,a}.
//   hex2seg()    : table lookup for one nibble.
package sevenseg_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
    return HEX_SEG[nibble];
  endfunction

endpackage

// File: rtl/sevenseg_scan_hex_to_7seg.sv
// hex_to_7seg: combinational nibble to seven-segment decode.
//   nibble : hex digit 0..F
//   seg    : active-high segment pattern {g,f,e,d,c,b,a}
module hex_to_7seg
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb seg = hex2seg(nibble);

endmodule

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: time-multiplexed common-anode seven-segment driver.
//   clk         : system clock
//   reset       : asynchronous reset, active low
//   enable      : scan enable; low forces the display dark
//   load        : one-cycle strobe capturing value/dp_in/blank_in as pending
//   value       : hex nibbles, digit 0 in the least-significant nibble
//   dp_in       : per-digit decimal point, 1 = lit
//   blank_in    : per-digit blank, 1 = dark
//   an          : anode enables, active low, one-hot-low while driving
//   seg         : cathodes {g,f,e,d,c,b,a}, active low
//   dp          : decimal-point cathode, active low
//   frame_start : one-cycle pulse when digit 0's slot begins
// Optional build macro SEVENSEG_LZ_BLANK_EN: blank leading zero digits
// (digit 0 always shown) when a new value is taken into the active set.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int DIGIT_CYCLES = 100000,
  parameter int GAP_CYCLES   = 2000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int CW = $clog2(DIGIT_CYCLES);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  scan_state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          frame_evt;

  logic [4*NUM_DIGITS-1:0] pend_value, act_value;
  logic [NUM_DIGITS-1:0]   pend_dp, pend_blank, act_dp, act_blank;
  logic                    pend_valid;
  logic [NUM_DIGITS-1:0]   blank_copy;

  logic [3:0]            cur_nib;
  logic                  cur_dp, cur_blank;
  logic [NUM_DIGITS-1:0] an_drive;
  logic [6:0]            seg_ah;

  // Slot counter runs through the gap and on into the drive phase, so a
  // slot is DIGIT_CYCLES long in total.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = ST_OFF;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          state_d = ST_BLANK;
          idx_d   = '0;
          cnt_d   = '0;
        end
        ST_BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(GAP_CYCLES - 1)) state_d = ST_DRIVE;
        end
        ST_DRIVE: begin
          if (cnt_q == CW'(DIGIT_CYCLES - 1)) begin
            cnt_d   = '0;
            state_d = ST_BLANK;
            idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
    frame_evt = (state_d == ST_BLANK) && (state_q != ST_BLANK) && (idx_d == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_OFF;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SEVENSEG_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  upper_zero;

  always_comb begin
    lz_mask    = '0;
    upper_zero = 1'b1;
    for (int unsigned k = NUM_DIGITS - 1; k > 0; k--) begin
      upper_zero = upper_zero && (pend_value[4*k +: 4] == 4'h0);
      lz_mask[k] = upper_zero;
    end
    blank_copy = pend_blank | lz_mask;
  end
`else
  always_comb blank_copy = pend_blank;
`endif

  // The frame-start copy reads pending before a coinciding load overwrites
  // it, so the older value goes active and the new one stays pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_value <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_valid <= 1'b0;
      act_value  <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
    end else begin
      if (frame_evt && pend_valid) begin
        act_value <= pend_value;
        act_dp    <= pend_dp;
        act_blank <= blank_copy;
      end
      if (load) begin
        pend_value <= value;
        pend_dp    <= dp_in;
        pend_blank <= blank_in;
        pend_valid <= 1'b1;
      end else if (frame_evt) begin
        pend_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_drive  = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib     = act_value[4*i +: 4];
        cur_dp      = act_dp[i];
        cur_blank   = act_blank[i];
        an_drive[i] = 1'b0;
      end
    end
  end

  hex_to_7seg u_dec (
    .nibble (cur_nib),
    .seg    (seg_ah)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an          <= '1;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_evt;
      if (state_q == ST_DRIVE) begin
        an  <= an_drive;
        seg <= cur_blank ? SEG_OFF : ~seg_ah;
        dp  <= cur_blank ? 1'b1 : ~cur_dp;
      end else begin
        an  <= '1;
        seg <= SEG_OFF;
        dp  <= 1'b1;
      end
    end
  end

endmodule
